// File: rtl/rv_mc_ctrl.sv
// Multi-cycle control sequencer for the RV32I core: FETCH/DECODE/EXEC/MEM/WB/TRAP.
// Optional retired-instruction counter enabled by defining RV_INSTRET_EN.
module rv_mc_ctrl (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic [6:0]  opcode_i,
  input  logic [4:0]  rd_i,
  input  logic        branch_taken_i,
  output logic        imem_req_o,
  input  logic        imem_ack_i,
  output logic        ir_we_o,
  output logic        dmem_req_o,
  output logic        dmem_we_o,
  input  logic        dmem_ack_i,
  output logic        pc_we_o,
  output logic [1:0]  pc_sel_o,
  output logic [1:0]  alu_a_sel_o,
  output logic        alu_b_sel_o,
  output logic        rf_we_o,
  output logic [1:0]  wb_sel_o,
  output logic        trap_o,
  output logic [31:0] instret_o
);

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_FENCE  = 7'b0001111;

  typedef enum logic [2:0] {
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_MEM,
    S_WB,
    S_TRAP
  } state_t;

  state_t     state_reg, state_next;
  logic       legal;
  logic [1:0] a_sel;
  logic       b_sel;

  // Opcode classification and the ALU operand selects for each class.
  always_comb begin
    legal = 1'b1;
    a_sel = 2'd0;
    b_sel = 1'b0;
    case (opcode_i)
      OPC_OP, OPC_BRANCH, OPC_FENCE: ;
      OPC_OP_IMM, OPC_LOAD, OPC_STORE, OPC_JALR: b_sel = 1'b1;
      OPC_JAL, OPC_AUIPC: begin
        a_sel = 2'd1;
        b_sel = 1'b1;
      end
      OPC_LUI: begin
        a_sel = 2'd2;
        b_sel = 1'b1;
      end
      default: legal = 1'b0;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) state_reg <= S_FETCH;
    else         state_reg <= state_next;
  end

  // Outputs stay at reset values while rst_ni is low, so no write lands in a reset cycle.
  always_comb begin
    state_next  = state_reg;
    imem_req_o  = 1'b0;
    ir_we_o     = 1'b0;
    dmem_req_o  = 1'b0;
    dmem_we_o   = 1'b0;
    pc_we_o     = 1'b0;
    pc_sel_o    = 2'd0;
    alu_a_sel_o = 2'd0;
    alu_b_sel_o = 1'b0;
    rf_we_o     = 1'b0;
    wb_sel_o    = 2'd0;
    trap_o      = 1'b0;
    if (rst_ni) begin
      case (state_reg)
        S_FETCH: begin
          imem_req_o = 1'b1;
          if (imem_ack_i) begin
            ir_we_o    = 1'b1;
            state_next = S_DECODE;
          end
        end
        S_DECODE: state_next = legal ? S_EXEC : S_TRAP;
        S_EXEC: begin
          alu_a_sel_o = a_sel;
          alu_b_sel_o = b_sel;
          case (opcode_i)
            OPC_LOAD, OPC_STORE: state_next = S_MEM;
            OPC_BRANCH: begin
              pc_we_o    = 1'b1;
              pc_sel_o   = branch_taken_i ? 2'd1 : 2'd0;
              state_next = S_FETCH;
            end
            OPC_FENCE: begin
              pc_we_o    = 1'b1;
              state_next = S_FETCH;
            end
            default: state_next = S_WB;
          endcase
        end
        S_MEM: begin
          alu_a_sel_o = a_sel;
          alu_b_sel_o = b_sel;
          dmem_req_o  = 1'b1;
          dmem_we_o   = (opcode_i == OPC_STORE);
          if (dmem_ack_i) begin
            if (opcode_i == OPC_STORE) begin
              pc_we_o    = 1'b1;
              state_next = S_FETCH;
            end else begin
              state_next = S_WB;
            end
          end
        end
        S_WB: begin
          alu_a_sel_o = a_sel;
          alu_b_sel_o = b_sel;
          rf_we_o     = (rd_i != 5'd0);
          pc_we_o     = 1'b1;
          state_next  = S_FETCH;
          case (opcode_i)
            OPC_LOAD: wb_sel_o = 2'd1;
            OPC_JAL: begin
              wb_sel_o = 2'd2;
              pc_sel_o = 2'd1;
            end
            OPC_JALR: begin
              wb_sel_o = 2'd2;
              pc_sel_o = 2'd2;
            end
            default: ;
          endcase
        end
        S_TRAP:  trap_o = 1'b1;
        default: state_next = S_FETCH;
      endcase
    end
  end

`ifdef RV_INSTRET_EN
  logic [31:0] instret_reg;

  // pc_we_o is never raised in TRAP, so the count freezes there.
  always_ff @(posedge clk_i) begin
    if (!rst_ni)      instret_reg <= 32'd0;
    else if (pc_we_o) instret_reg <= instret_reg + 32'd1;
  end

  assign instret_o = instret_reg;
`else
  assign instret_o = 32'd0;
`endif

endmodule

// File: tb/tb_rv_mc_ctrl.sv
// Self-checking bench for rv_mc_ctrl: directed vector table, multi-cycle corner
// sequences and randomized instructions checked against an instruction-class model.
module tb_rv_mc_ctrl;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_FENCE  = 7'b0001111;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic [6:0]  opcode_i = 7'd0;
  logic [4:0]  rd_i = 5'd0;
  logic        branch_taken_i = 1'b0;
  logic        imem_ack_i = 1'b0;
  logic        dmem_ack_i = 1'b0;
  logic        imem_req_o, ir_we_o, dmem_req_o, dmem_we_o, pc_we_o;
  logic        alu_b_sel_o, rf_we_o, trap_o;
  logic [1:0]  pc_sel_o, alu_a_sel_o, wb_sel_o;
  logic [31:0] instret_o;

  int          n_checks = 0;
  int          n_errors = 0;
  logic [31:0] exp_instret = 32'd0;

  always #5 clk_i = ~clk_i;

  rv_mc_ctrl dut (
    .clk_i          (clk_i),
    .rst_ni         (rst_ni),
    .opcode_i       (opcode_i),
    .rd_i           (rd_i),
    .branch_taken_i (branch_taken_i),
    .imem_req_o     (imem_req_o),
    .imem_ack_i     (imem_ack_i),
    .ir_we_o        (ir_we_o),
    .dmem_req_o     (dmem_req_o),
    .dmem_we_o      (dmem_we_o),
    .dmem_ack_i     (dmem_ack_i),
    .pc_we_o        (pc_we_o),
    .pc_sel_o       (pc_sel_o),
    .alu_a_sel_o    (alu_a_sel_o),
    .alu_b_sel_o    (alu_b_sel_o),
    .rf_we_o        (rf_we_o),
    .wb_sel_o       (wb_sel_o),
    .trap_o         (trap_o),
    .instret_o      (instret_o)
  );

  typedef struct packed {
    int          cycles;
    int          imem_cycles;
    int          ir_we_cnt;
    int          ir_we_idx;
    int          dmem_cycles;
    logic        dmem_we;
    logic [1:0]  pc_sel;
    int          rf_we_cnt;
    logic [1:0]  wb_sel;
    logic [1:0]  a_ex;
    logic        b_ex;
    logic [1:0]  a_ret;
    logic        b_ret;
    int          mem_sel_bad;
    logic        trap;
    logic [31:0] instret_start;
  } obs_t;

  typedef struct packed {
    int         cycles;
    int         dmem_cycles;
    logic       dmem_we;
    logic [1:0] pc_sel;
    logic       rf_we;
    logic       chk_wb;
    logic [1:0] wb_sel;
    logic       chk_ex;
    logic [1:0] a_ex;
    logic       b_ex;
    logic       chk_ret;
    logic [1:0] a_ret;
    logic       b_ret;
  } exp_t;

  typedef struct {
    logic [6:0] op;
    logic [4:0] rd;
    logic       tk;
    int         iw;
    int         dw;
    exp_t       e;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, expv);
    end
  endtask

  function automatic exp_t mk_exp(input int cyc, input int dcyc, input logic dwe,
                                  input logic [1:0] psel, input logic rfwe,
                                  input logic chkwb, input logic [1:0] wbsel);
    exp_t e;
    e = '0;
    e.cycles = cyc;
    e.dmem_cycles = dcyc;
    e.dmem_we = dwe;
    e.pc_sel = psel;
    e.rf_we = rfwe;
    e.chk_wb = chkwb;
    e.wb_sel = wbsel;
    return e;
  endfunction

  // Reference: latency from the phases each instruction class passes through.
  function automatic exp_t model(input logic [6:0] op, input logic [4:0] rd, input logic tk,
                                 input int iw, input int dw);
    exp_t e;
    logic is_mem, is_wb;
    e = '0;
    is_mem = 1'b0;
    is_wb = 1'b0;
    e.chk_ex = 1'b1;
    case (op)
      OPC_OP:     is_wb = 1'b1;
      OPC_OP_IMM: begin is_wb = 1'b1; e.b_ex = 1'b1; end
      OPC_LUI:    begin is_wb = 1'b1; e.a_ex = 2'd2; e.b_ex = 1'b1; end
      OPC_AUIPC:  begin is_wb = 1'b1; e.a_ex = 2'd1; e.b_ex = 1'b1; end
      OPC_JAL:    begin is_wb = 1'b1; e.a_ex = 2'd1; e.b_ex = 1'b1; e.pc_sel = 2'd1;
                        e.wb_sel = 2'd2; e.chk_ret = 1'b1; end
      OPC_JALR:   begin is_wb = 1'b1; e.b_ex = 1'b1; e.pc_sel = 2'd2;
                        e.wb_sel = 2'd2; e.chk_ret = 1'b1; end
      OPC_LOAD:   begin is_mem = 1'b1; is_wb = 1'b1; e.b_ex = 1'b1; e.wb_sel = 2'd1; end
      OPC_STORE:  begin is_mem = 1'b1; e.b_ex = 1'b1; e.dmem_we = 1'b1; end
      OPC_BRANCH: e.pc_sel = tk ? 2'd1 : 2'd0;
      default:    e.chk_ex = 1'b0;
    endcase
    e.a_ret = e.a_ex;
    e.b_ret = e.b_ex;
    e.rf_we = is_wb && (rd != 5'd0);
    e.chk_wb = is_wb;
    e.dmem_cycles = is_mem ? dw + 1 : 0;
    e.cycles = 3 + iw + e.dmem_cycles + (is_wb ? 1 : 0);
    return e;
  endfunction

  // Steps one instruction cycle by cycle: acks arrive after iw/dw wait cycles, random otherwise.
  task automatic run_instr(input logic [6:0] op, input logic [4:0] rd, input logic tk,
                           input int iw, input int dw, output obs_t o);
    int cyc;
    int ireq;
    int dreq;
    o = '0;
    cyc = 0;
    ireq = 0;
    dreq = 0;
    while (cyc < 64) begin
      @(negedge clk_i);
      if (cyc == 0) begin
        opcode_i = op;
        rd_i = rd;
      end
      branch_taken_i = tk;
      imem_ack_i = imem_req_o ? (ireq == iw) : 1'($urandom_range(0, 1));
      dmem_ack_i = dmem_req_o ? (dreq == dw) : 1'($urandom_range(0, 1));
      #1;
      if (cyc == 0) o.instret_start = instret_o;
      if (imem_req_o) ireq++;
      if (dmem_req_o) begin
        dreq++;
        if (dmem_we_o) o.dmem_we = 1'b1;
        if (alu_a_sel_o != 2'd0 || alu_b_sel_o != 1'b1) o.mem_sel_bad++;
      end
      if (ir_we_o) begin
        o.ir_we_cnt++;
        o.ir_we_idx = cyc;
      end
      if (cyc == iw + 2) begin
        o.a_ex = alu_a_sel_o;
        o.b_ex = alu_b_sel_o;
      end
      if (rf_we_o) o.rf_we_cnt++;
      if (trap_o) o.trap = 1'b1;
      cyc++;
      if (pc_we_o) begin
        o.cycles = cyc;
        o.pc_sel = pc_sel_o;
        o.wb_sel = wb_sel_o;
        o.a_ret = alu_a_sel_o;
        o.b_ret = alu_b_sel_o;
        break;
      end
      if (trap_o) break;
    end
    o.imem_cycles = ireq;
    o.dmem_cycles = dreq;
  endtask

  task automatic check_obs(input string tag, input obs_t o, input exp_t e, input int iw);
    check({tag, ".cycles"}, o.cycles, e.cycles);
    check({tag, ".imem_req_cycles"}, o.imem_cycles, iw + 1);
    check({tag, ".ir_we_count"}, o.ir_we_cnt, 1);
    check({tag, ".ir_we_cycle"}, o.ir_we_idx, iw);
    check({tag, ".dmem_req_cycles"}, o.dmem_cycles, e.dmem_cycles);
    check({tag, ".dmem_we"}, o.dmem_we, e.dmem_we);
    check({tag, ".pc_sel"}, o.pc_sel, e.pc_sel);
    check({tag, ".rf_we_count"}, o.rf_we_cnt, e.rf_we);
    if (e.chk_wb) check({tag, ".wb_sel"}, o.wb_sel, e.wb_sel);
    if (e.chk_ex) begin
      check({tag, ".alu_a_exec"}, o.a_ex, e.a_ex);
      check({tag, ".alu_b_exec"}, o.b_ex, e.b_ex);
    end
    if (e.chk_ret) begin
      check({tag, ".alu_a_wb"}, o.a_ret, e.a_ret);
      check({tag, ".alu_b_wb"}, o.b_ret, e.b_ret);
    end
    check({tag, ".mem_sel_hold"}, o.mem_sel_bad, 0);
    check({tag, ".trap"}, o.trap, 1'b0);
    check({tag, ".instret"}, o.instret_start, exp_instret);
`ifdef RV_INSTRET_EN
    exp_instret = exp_instret + 32'd1;
`endif
  endtask

  task automatic apply_reset(input int n);
    @(negedge clk_i);
    rst_ni = 1'b0;
    imem_ack_i = 1'b0;
    dmem_ack_i = 1'b0;
    repeat (n) @(posedge clk_i);
    @(negedge clk_i);
    #1;
    check("rst.imem_req", imem_req_o, 1'b0);
    check("rst.enables", {ir_we_o, dmem_req_o, dmem_we_o, pc_we_o, rf_we_o, trap_o}, 6'd0);
    check("rst.selects", {pc_sel_o, alu_a_sel_o, alu_b_sel_o, wb_sel_o}, 7'd0);
    check("rst.instret", instret_o, 32'd0);
    rst_ni = 1'b1;
    exp_instret = 32'd0;
    #1;
    check("rst.req_after_release", imem_req_o, 1'b1);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t       vecs[10];
    logic [6:0] legal_ops[10];
    obs_t       o;
    exp_t       e;
    int         bad;

    vecs[0] = '{OPC_OP_IMM, 5'd1,  1'b0, 0, 0, mk_exp(4, 0, 1'b0, 2'd0, 1'b1, 1'b1, 2'd0)};
    vecs[1] = '{OPC_LOAD,   5'd5,  1'b0, 0, 3, mk_exp(8, 4, 1'b0, 2'd0, 1'b1, 1'b1, 2'd1)};
    vecs[2] = '{OPC_BRANCH, 5'd3,  1'b1, 0, 0, mk_exp(3, 0, 1'b0, 2'd1, 1'b0, 1'b0, 2'd0)};
    vecs[3] = '{OPC_BRANCH, 5'd3,  1'b0, 0, 0, mk_exp(3, 0, 1'b0, 2'd0, 1'b0, 1'b0, 2'd0)};
    vecs[4] = '{OPC_JALR,   5'd0,  1'b0, 0, 0, mk_exp(4, 0, 1'b0, 2'd2, 1'b0, 1'b1, 2'd2)};
    vecs[5] = '{OPC_JAL,    5'd1,  1'b0, 0, 0, mk_exp(4, 0, 1'b0, 2'd1, 1'b1, 1'b1, 2'd2)};
    vecs[6] = '{OPC_STORE,  5'd7,  1'b0, 2, 1, mk_exp(7, 2, 1'b1, 2'd0, 1'b0, 1'b0, 2'd0)};
    vecs[7] = '{OPC_FENCE,  5'd2,  1'b0, 1, 0, mk_exp(4, 0, 1'b0, 2'd0, 1'b0, 1'b0, 2'd0)};
    vecs[8] = '{OPC_LUI,    5'd0,  1'b0, 0, 0, mk_exp(4, 0, 1'b0, 2'd0, 1'b0, 1'b1, 2'd0)};
    vecs[9] = '{OPC_OP,     5'd31, 1'b1, 3, 0, mk_exp(7, 0, 1'b0, 2'd0, 1'b1, 1'b1, 2'd0)};
    legal_ops = '{OPC_OP, OPC_OP_IMM, OPC_LOAD, OPC_STORE, OPC_BRANCH,
                  OPC_JAL, OPC_JALR, OPC_LUI, OPC_AUIPC, OPC_FENCE};

    apply_reset(2);

    for (int i = 0; i < 10; i++) begin
      run_instr(vecs[i].op, vecs[i].rd, vecs[i].tk, vecs[i].iw, vecs[i].dw, o);
      $display("vec %0d op=%b rd=%0d tk=%0b iw=%0d dw=%0d cycles=%0d pc_sel=%0d rf_we=%0d wb_sel=%0d",
               i, vecs[i].op, vecs[i].rd, vecs[i].tk, vecs[i].iw, vecs[i].dw,
               o.cycles, o.pc_sel, o.rf_we_cnt, o.wb_sel);
      check_obs($sformatf("vec%0d", i), o, vecs[i].e, vecs[i].iw);
    end

`ifdef RV_INSTRET_EN
    // Retire of the JAL below runs the counter from all-ones through zero.
    run_instr(OPC_JAL, 5'd1, 1'b0, 0, 0, o);
    check_obs("wrap_pre", o, model(OPC_JAL, 5'd1, 1'b0, 0, 0), 0);
    dut.instret_reg = 32'hFFFF_FFFF;
    exp_instret = 32'd0;
    run_instr(OPC_OP, 5'd1, 1'b0, 0, 0, o);
    $display("wrap instret_start=%0h", o.instret_start);
    check_obs("wrap", o, model(OPC_OP, 5'd1, 1'b0, 0, 0), 0);
`endif

    // Reset during the MEM ack cycle of a store: no PC write, FETCH afterwards.
    @(negedge clk_i);
    opcode_i = OPC_STORE;
    rd_i = 5'd0;
    imem_ack_i = 1'b1;
    dmem_ack_i = 1'b0;
    #1 check("sw_rst.ir_we", ir_we_o, 1'b1);
    @(negedge clk_i);
    imem_ack_i = 1'b0;
    @(negedge clk_i);
    #1 check("sw_rst.exec_b_sel", alu_b_sel_o, 1'b1);
    @(negedge clk_i);
    #1 check("sw_rst.mem_req", {dmem_req_o, dmem_we_o}, 2'b11);
    dmem_ack_i = 1'b1;
    rst_ni = 1'b0;
    #1 check("sw_rst.pc_we", {pc_we_o, rf_we_o}, 2'b00);
    @(negedge clk_i);
    dmem_ack_i = 1'b0;
    rst_ni = 1'b1;
    exp_instret = 32'd0;
    #1;
    $display("sw_rst imem_req=%0b dmem_req=%0b instret=%0h", imem_req_o, dmem_req_o, instret_o);
    check("sw_rst.fetch_next", {imem_req_o, dmem_req_o}, 2'b10);
    check("sw_rst.instret", instret_o, 32'd0);

    // Illegal opcode: TRAP from cycle 2, silent for 20 cycles, left only by reset.
    @(negedge clk_i);
    opcode_i = 7'b1111111;
    imem_ack_i = 1'b1;
    @(negedge clk_i);
    imem_ack_i = 1'b0;
    #1 check("trap.decode_trap", trap_o, 1'b0);
    @(negedge clk_i);
    #1 check("trap.cycle2", trap_o, 1'b1);
    bad = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk_i);
      imem_ack_i = 1'($urandom_range(0, 1));
      dmem_ack_i = 1'($urandom_range(0, 1));
      #1;
      if (imem_req_o | dmem_req_o | ir_we_o | pc_we_o | rf_we_o | dmem_we_o | !trap_o) bad++;
    end
    $display("trap quiet_cycles=20 violations=%0d instret=%0h", bad, instret_o);
    check("trap.quiet", bad, 0);
    check("trap.instret_frozen", instret_o, exp_instret);
    apply_reset(1);
    check("trap.cleared", trap_o, 1'b0);

    for (int i = 0; i < 40; i++) begin
      logic [6:0] op;
      logic [4:0] rd;
      logic       tk;
      int         iw;
      int         dw;
      op = legal_ops[$urandom_range(0, 9)];
      rd = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      tk = 1'($urandom_range(0, 1));
      iw = $urandom_range(0, 3);
      dw = $urandom_range(0, 3);
      e = model(op, rd, tk, iw, dw);
      run_instr(op, rd, tk, iw, dw, o);
      $display("rnd %0d op=%b rd=%0d tk=%0b iw=%0d dw=%0d cycles=%0d/%0d pc_sel=%0d",
               i, op, rd, tk, iw, dw, o.cycles, e.cycles, o.pc_sel);
      check_obs($sformatf("rnd%0d", i), o, e, iw);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
